// File: rtl/thread_wait_queue_pkg.sv
// Shared thread-id type and the dequeue-selection encoding used by the wait queue.
package EV_types;
  typedef logic [3:0] thread_id_t;
endpackage

package thread_wait_queue_pkg;
  typedef enum logic [1:0] {
    DEQ_NONE,
    DEQ_HEAD,
    DEQ_SECOND
  } deq_sel_e;
endpackage

// File: rtl/thread_wait_queue.sv
// Age-ordered wait queue of parked thread ids; the scheduler may claim the head
// or the second-oldest entry, and new threads are appended at the tail.
module thread_wait_queue
  import EV_types::*;
  import thread_wait_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enq_valid,
  input  thread_id_t enq_id,
  input  logic       requesting_thread,
  input  thread_id_t requested_thread_id,
  output thread_id_t waiting_thread_count,
  output thread_id_t waiting_next_id,
  output thread_id_t waiting_next_id2,
  output logic       overflow_err,
  output logic       dup_err
);

  thread_id_t entries_q [DEPTH];
  thread_id_t entries_d [DEPTH];
  thread_id_t mid       [DEPTH];
  thread_id_t count_q, count_d, mid_count;
  logic       ovf_q, ovf_d, dup_q, dup_d;
  logic       hit;
  deq_sel_e   deq_sel;

  always_comb begin
    deq_sel = DEQ_NONE;
    if (requesting_thread) begin
      if (count_q != '0 && requested_thread_id == entries_q[0])
        deq_sel = DEQ_HEAD;
      else if (count_q >= thread_id_t'(2) && requested_thread_id == entries_q[1])
        deq_sel = DEQ_SECOND;
    end

    // Dequeue is applied first; the enqueue then sees the post-removal contents.
    mid       = entries_q;
    mid_count = count_q;
    case (deq_sel)
      DEQ_HEAD: begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) mid[i] = entries_q[i+1];
        mid[DEPTH-1] = '0;
        mid_count    = count_q - thread_id_t'(1);
      end
      DEQ_SECOND: begin
        for (int unsigned i = 1; i < DEPTH - 1; i++) mid[i] = entries_q[i+1];
        mid[DEPTH-1] = '0;
        mid_count    = count_q - thread_id_t'(1);
      end
      default: ;
    endcase

    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (thread_id_t'(i) < mid_count && mid[i] == enq_id) hit = 1'b1;

    entries_d = mid;
    count_d   = mid_count;
    ovf_d     = ovf_q;
    dup_d     = dup_q;
    if (enq_valid) begin
      if (hit) begin
        dup_d = 1'b1;
      end else if (mid_count == thread_id_t'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++)
          if (thread_id_t'(i) == mid_count) entries_d[i] = enq_id;
        count_d = mid_count + thread_id_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      dup_q     <= dup_d;
    end
  end

  // Slots beyond the count are held at zero, so the raw head/second registers
  // already read as zero when the queue is too short.
  assign waiting_thread_count = count_q;
  assign waiting_next_id      = entries_q[0];
  assign waiting_next_id2     = entries_q[1];
  assign overflow_err         = ovf_q;
  assign dup_err              = dup_q;

endmodule

// File: doc/thread_wait_queue.md
THREAD_WAIT_QUEUE -- requirements
Module: thread_wait_queue

Interface
REQ-001 Parameter DEPTH, default 7, max threads parked; SHALL satisfy 2 <= DEPTH <= 2**$bits(thread_id_t)-1.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk only.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 enq_valid  input  1  a thread is parked (waiting for issue slot) this cycle.
REQ-005 enq_id  input  thread_id_t  id of the parked thread.
REQ-006 requesting_thread  input  1  scheduler claims a thread this cycle.
REQ-007 requested_thread_id  input  thread_id_t  id claimed.
REQ-008 waiting_thread_count  output  thread_id_t  number of valid entries.
REQ-009 waiting_next_id  output  thread_id_t  oldest entry (head).
REQ-010 waiting_next_id2  output  thread_id_t  second-oldest entry.
REQ-011 overflow_err  output  1  sticky: enqueue dropped because queue full.
REQ-012 dup_err  output  1  sticky: enqueue dropped because id already queued.

Function
REQ-013 Storage SHALL be an age-ordered array of DEPTH entries, entry 0 = head, plus registered count.
REQ-014 All outputs SHALL be registered; an operation presented in cycle N SHALL be visible on outputs from cycle N+1 (1-cycle latency).
REQ-015 waiting_next_id SHALL be 0 when count==0; waiting_next_id2 SHALL be 0 when count<2.
REQ-016 Dequeue SHALL be evaluated against contents at start of cycle: id==entry0 -> remove head, shift all up one; else id==entry1 (count>=2) -> remove entry1, shift entries 2.. up one, head kept.
REQ-017 Dequeue with id matching neither entry0 nor entry1 (thread returning from memory, not parked) SHALL leave contents unchanged and raise no error.
REQ-018 Enqueue SHALL append enq_id at the tail after any same-cycle dequeue is applied.
REQ-019 Same-cycle enqueue and dequeue SHALL net count unchanged when both take effect.
REQ-020 Enqueue when full SHALL succeed if a same-cycle dequeue removes an entry; otherwise dropped and overflow_err set.
REQ-021 Enqueue of an id present after the same-cycle dequeue SHALL be dropped and dup_err set; enqueue of the id being dequeued that cycle SHALL be accepted (re-park at tail).
REQ-022 Entries at index >= count SHALL be held at 0.
REQ-023 count SHALL never exceed DEPTH nor wrap below 0.
REQ-024 overflow_err and dup_err SHALL remain 1 until rst.

Reset
REQ-025 On rst: count=0, all entries=0, waiting_next_id=0, waiting_next_id2=0, overflow_err=0, dup_err=0.
REQ-026 rst SHALL dominate; enqueue/dequeue presented in the rst cycle SHALL be discarded, including mid-operation.
REQ-027 First operation after rst deasserts SHALL be accepted normally.

Structure
REQ-028 thread_id_t SHALL come from EV_types; no new typedef is needed, DEPTH is a module parameter.
REQ-029 Module SHALL be flat; no sub-module; removal/shift logic in one always_ff with combinational next-state.
REQ-030 Register updates SHALL use the codebase #CQ clock-to-Q delay.

Verification
REQ-031 Enqueue 3,5,7 on consecutive cycles -> next cycle after last: count=3, next_id=3, next_id2=5.
REQ-032 Queue {3,5,7}, dequeue 5 -> count=2, next_id=3, next_id2=7; then dequeue 3 -> count=1, next_id=7, next_id2=0.
REQ-033 Queue {3,5}, dequeue 6 -> contents unchanged, no error flag.
REQ-034 Fill DEPTH=7 with ids 1..7, enqueue 8 -> dropped, overflow_err=1; enqueue 8 with dequeue 1 same cycle -> count=7, next_id=2, tail=8.
REQ-035 Queue {4}, enqueue 4 -> dup_err=1, count=1; queue {4}, enqueue 4 with dequeue 4 same cycle -> count=1, next_id=4, dup_err=0.
REQ-036 Queue {2,3}, assert rst with enqueue 9 same cycle -> count=0, outputs 0, errors 0; next cycle enqueue 9 -> count=1, next_id=9.
